idecoder_q: RTL and testbench
=============================

Name: idecoder_q

Overview:
- Queued, parametrised instruction decode stage for the 16-bit CPU datapath.
- Accepts raw instruction words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the fully decoded head instruction (opcode, ALU/shift ops, sign-extended immediates, register addresses) to the controller.
- Lets fetch run ahead of the controller FSM by up to DEPTH instructions.

Parameters:
- DATA_W, 16, width of sximm5/sximm8 outputs; legal range is 8 or more.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous queue clear (branch taken)
- in_valid  input  1  ir is valid
- in_ready  output  1  queue can accept an instruction
- ir  input  16  raw instruction word
- out_valid  output  1  head entry is valid
- out_ready  input  1  controller consumes the head this cycle
- reg_sel  input  2  register select: 10 = Rn, 01 = Rd, 00 = Rm, 11 = reserved
- opcode  output  3  head ir[15:13]
- ALU_op  output  2  head ir[12:11]
- shift_op  output  2  head ir[4:3]
- sximm5  output  DATA_W  sign-extended head ir[4:0]
- sximm8  output  DATA_W  sign-extended head ir[7:0]
- r_addr  output  3  register selected by reg_sel
- w_addr  output  3  same value as r_addr
- count  output  clog2(DEPTH)+1  occupancy
- illegal  output  1  head instruction is illegal (see Optional Feature)

Behaviour:
- Field map:
  - Rn = ir[10:8], Rd = ir[7:5], Rm = ir[2:0].
  - reg_sel 11 drives r_addr = w_addr = 3'b000.
- Storage:
  - Each FIFO entry stores the raw 16-bit word.
  - Decode is combinational from the head entry register only; there is no combinational path from ir to any decode output.
- Push and pop:
  - Push happens when in_valid && in_ready.
  - Pop happens when out_valid && out_ready.
  - in_ready = (count != DEPTH). It does not depend on out_ready, so there is no ready-through path.
  - out_valid = (count != 0).
- Latency:
  - A word accepted at edge N is visible on the outputs after edge N when the queue was empty before N. Otherwise it becomes visible after the pops of all older entries.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - When full, in_ready = 0, so no push is accepted even if a pop occurs in the same cycle.
- Empty queue:
  - out_valid = 0.
  - opcode, ALU_op, shift_op, sximm5, sximm8, r_addr, w_addr and illegal are all driven to 0.
- Pop while empty and push while full are both ignored; pointers and count do not move.
- Pointers:
  - Read and write pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy from 0 to DEPTH.
- rst:
  - Clears pointers and count to 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, all decode outputs = 0.
  - Asserting rst mid-stream discards all queued entries.
- flush:
  - Same clearing effect as rst.
  - Has priority over a push or pop in the same cycle; an instruction presented with flush is dropped.
- reg_sel is purely combinational onto r_addr/w_addr. The controller may change it on every cycle without popping.

Optional Feature:
- Macro: IDEC_ILLEGAL_DET_EN.
- When defined, illegal is high when out_valid is high and the head instruction is not in the legal set:
  - opcode 101 with any ALU_op;
  - opcode 110 with ALU_op 00 or 10;
  - opcode 011, 100 or 111, each with ALU_op 00.
- An illegal instruction is still queued and popped normally; illegal is a flag only.
- When the macro is undefined, illegal is tied to 0.

Test Plan:
- Single instruction:
  - Stimulus: after reset, push 16'b1101000000100010.
  - Next cycle: out_valid = 1, opcode = 110, ALU_op = 10, shift_op = 00, sximm8 = 16'h0022, sximm5 = 16'h0002.
  - reg_sel 10/01/00 gives r_addr = w_addr = 000/001/010.
- Negative sximm5:
  - Stimulus: push 16'b1010001000111000.
  - Response: opcode = 101, ALU_op = 00, shift_op = 11, sximm8 = 16'h0038, sximm5 = 16'hFFF8.
  - Rn/Rd/Rm = 010/001/000.
- Fill, drain and wrap:
  - Stimulus: push DEPTH+1 words with out_ready = 0.
  - While filling: in_ready drops after 4 accepts and count = 4; the 5th word is held by the source.
  - Drain: pops return words in FIFO order.
  - Wrap: push and pop continue across pointer wrap for 10 words with no loss or reorder.
- Simultaneous push and pop at count = 2:
  - Count stays 2.
  - The head advances to the next older entry.
- Flush and reset:
  - Stimulus: with 3 entries queued, assert flush together with in_valid.
  - Response: count = 0, out_valid = 0, all outputs 0, and the pushed word is dropped.
  - Repeating the scenario with rst instead of flush gives the same result.
- IDEC_ILLEGAL_DET_EN:
  - Stimulus: push opcode 110 with ALU_op 01 (16'hC800).
  - With the macro defined: illegal = 1.
  - With the macro undefined: illegal = 0.
  - In both builds the entry pops normally.

Source files
------------

// File: rtl/idecoder_q.sv
// idecoder_q - queued instruction decode stage for the 16-bit CPU datapath.
//
// Raw instruction words are pushed over a valid/ready handshake into a
// DEPTH-entry FIFO. The head entry is decoded combinationally and presented
// to the controller, which pops it with out_ready. Fetch can therefore run
// ahead of the controller by up to DEPTH instructions.
//
// Optional build macro: IDEC_ILLEGAL_DET_EN
//   defined   - illegal flags a head instruction outside the legal set
//   undefined - illegal is tied low
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, discards queued entries
//   flush      synchronous queue clear (branch taken), beats push/pop
//   in_valid   ir carries an instruction
//   in_ready   queue has room (count != DEPTH)
//   ir         raw instruction word
//   out_valid  head entry is valid (count != 0)
//   out_ready  controller consumes the head this cycle
//   reg_sel    10 = Rn, 01 = Rd, 00 = Rm, 11 = reserved (address 0)
//   opcode     head ir[15:13]
//   ALU_op     head ir[12:11]
//   shift_op   head ir[4:3]
//   sximm5     sign-extended head ir[4:0]
//   sximm8     sign-extended head ir[7:0]
//   r_addr     register selected by reg_sel
//   w_addr     same value as r_addr
//   count      occupancy, 0..DEPTH
//   illegal    head instruction is illegal (optional feature)
//
// All decode outputs read 0 while the queue is empty.

module idecoder_q #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               ir,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic [1:0]                reg_sel,
    output logic [2:0]                opcode,
    output logic [1:0]                ALU_op,
    output logic [1:0]                shift_op,
    output logic [DATA_W-1:0]         sximm5,
    output logic [DATA_W-1:0]         sximm8,
    output logic [2:0]                r_addr,
    output logic [2:0]                w_addr,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [15:0]      head;

    // in_ready looks only at occupancy, never at out_ready, so a full
    // queue refuses a push even in a cycle where it also pops.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; entries are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= ir;
        end
    end

    assign head = mem[rd_ptr];

    // Decode comes from the stored head only, so ir never reaches an output
    // combinationally.
    always_comb begin
        opcode   = '0;
        ALU_op   = '0;
        shift_op = '0;
        sximm5   = '0;
        sximm8   = '0;
        r_addr   = '0;
        if (out_valid) begin
            opcode   = head[15:13];
            ALU_op   = head[12:11];
            shift_op = head[4:3];
            sximm5   = {{(DATA_W-5){head[4]}}, head[4:0]};
            sximm8   = {{(DATA_W-8){head[7]}}, head[7:0]};
            case (reg_sel)
                2'b10:   r_addr = head[10:8];
                2'b01:   r_addr = head[7:5];
                2'b00:   r_addr = head[2:0];
                default: r_addr = 3'b000;
            endcase
        end
    end

    assign w_addr = r_addr;

`ifdef IDEC_ILLEGAL_DET_EN
    logic legal;

    always_comb begin
        legal = 1'b0;
        case (head[15:13])
            3'b101:                legal = 1'b1;
            3'b110:                legal = (head[12:11] == 2'b00) || (head[12:11] == 2'b10);
            3'b011, 3'b100, 3'b111: legal = (head[12:11] == 2'b00);
            default:               legal = 1'b0;
        endcase
    end

    assign illegal = out_valid && !legal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_idecoder_q.sv
// tb_idecoder_q - directed self-checking bench for idecoder_q (DEPTH = 4,
// DATA_W = 16). Inputs change 1 ns after the rising edge; outputs are read
// before the next rising edge.

module tb_idecoder_q;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ir;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  reg_sel;
    logic [2:0]  opcode;
    logic [1:0]  ALU_op;
    logic [1:0]  shift_op;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [2:0]  r_addr;
    logic [2:0]  w_addr;
    logic [2:0]  count;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    idecoder_q #(.DATA_W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .reg_sel   (reg_sel),
        .opcode    (opcode),
        .ALU_op    (ALU_op),
        .shift_op  (shift_op),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .r_addr    (r_addr),
        .w_addr    (w_addr),
        .count     (count),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rebuilds the raw head word from the decode outputs:
    // opcode, ALU_op, Rn (via reg_sel 10) and the low 8 bits of sximm8.
    task automatic read_head(output logic [15:0] w);
        reg_sel = 2'b10;
        #1;
        w = {opcode, ALU_op, r_addr, sximm8[7:0]};
        reg_sel = 2'b00;
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, " count"},     32'(count), 32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready"},  32'(in_ready), 32'd1);
        check({tag, " decode"},    {opcode, ALU_op, shift_op, r_addr, w_addr, illegal},
              32'd0);
        check({tag, " imm"},       {sximm5, sximm8}, 32'd0);
    endtask

    logic [15:0] fill_w [5] = '{16'hA5C3, 16'h5A3C, 16'hF00F, 16'h0FF0, 16'h8421};
    logic [15:0] q [$];
    logic [15:0] hw;
    logic [15:0] sw;
    logic        exp_pop;
    logic        exp_ill;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ir = '0;
        out_ready = 1'b0; reg_sel = 2'b00;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_empty("reset");

        // Single instruction
        in_valid = 1'b1; ir = 16'b1101000000100010;
        tick();
        in_valid = 1'b0;
        check("single out_valid", 32'(out_valid), 32'd1);
        check("single fields", {opcode, ALU_op, shift_op}, {3'b110, 2'b10, 2'b00});
        check("single sximm8", 32'(sximm8), 32'h0022);
        check("single sximm5", 32'(sximm5), 32'h0002);
        check("single count", 32'(count), 32'd1);
        check("single illegal", 32'(illegal), 32'd0);
        reg_sel = 2'b10; #1;
        check("single Rn", {r_addr, w_addr}, {3'b000, 3'b000});
        reg_sel = 2'b01; #1;
        check("single Rd", {r_addr, w_addr}, {3'b001, 3'b001});
        reg_sel = 2'b00; #1;
        check("single Rm", {r_addr, w_addr}, {3'b010, 3'b010});
        reg_sel = 2'b11; #1;
        check("single reserved sel", {r_addr, w_addr}, {3'b000, 3'b000});
        reg_sel = 2'b00;
        out_ready = 1'b1;
        tick();
        check_empty("single popped");
        // Pop while empty must not move anything
        tick();
        out_ready = 1'b0;
        check("pop empty count", 32'(count), 32'd0);

        // Negative sximm5
        in_valid = 1'b1; ir = 16'b1010001000111000;
        tick();
        in_valid = 1'b0;
        check("neg fields", {opcode, ALU_op, shift_op}, {3'b101, 2'b00, 2'b11});
        check("neg sximm8", 32'(sximm8), 32'h0038);
        check("neg sximm5", 32'(sximm5), 32'hFFF8);
        reg_sel = 2'b10; #1; check("neg Rn", 32'(r_addr), 32'd2);
        reg_sel = 2'b01; #1; check("neg Rd", 32'(r_addr), 32'd1);
        reg_sel = 2'b00; #1; check("neg Rm", 32'(r_addr), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("neg popped count", 32'(count), 32'd0);

        // Fill with out_ready low: 4 accepted, 5th held
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ir = fill_w[i];
            #1;
            check($sformatf("fill in_ready %0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        check("full count", 32'(count), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        check("push full count", 32'(count), 32'd4);

        // Drain in FIFO order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_head(hw);
            check($sformatf("drain head %0d", i), 32'(hw), 32'(fill_w[i]));
            tick();
        end
        out_ready = 1'b0;
        check("drained count", 32'(count), 32'd0);

        // Stream 10 words through with push and pop together, across wraps
        q.delete();
        for (int c = 0; c <= 10; c++) begin
            sw = 16'(16'h0101 + c * 16'h1357);
            in_valid = (c < 10); ir = sw; out_ready = 1'b1;
            exp_pop = (q.size() != 0);
            if (exp_pop) begin
                read_head(hw);
                check($sformatf("stream head %0d", c), 32'(hw), 32'(q[0]));
            end
            check($sformatf("stream out_valid %0d", c), 32'(out_valid), 32'(exp_pop));
            tick();
            if (exp_pop) void'(q.pop_front());
            if (c < 10) q.push_back(sw);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream end count", 32'(count), 32'd0);

        // Simultaneous push and pop at count 2
        in_valid = 1'b1; ir = 16'h6111; tick();
        ir = 16'h6222; tick();
        check("pp pre count", 32'(count), 32'd2);
        ir = 16'h6333; out_ready = 1'b1; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp count", 32'(count), 32'd2);
        read_head(hw);
        check("pp head", 32'(hw), 32'h6222);

        // Flush with 3 entries and a word presented
        in_valid = 1'b1; ir = 16'h6444; tick();
        check("flush pre count", 32'(count), 32'd3);
        ir = 16'h6555; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check_empty("flush");
        tick();
        check("flush dropped count", 32'(count), 32'd0);

        // Same scenario with rst
        in_valid = 1'b1;
        ir = 16'h7111; tick();
        ir = 16'h7222; tick();
        ir = 16'h7333; tick();
        check("rst pre count", 32'(count), 32'd3);
        ir = 16'h7444; rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        check_empty("rst mid");
        tick();
        check("rst dropped count", 32'(count), 32'd0);
        // Queue still works after the clear
        in_valid = 1'b1; ir = 16'h7555; tick();
        in_valid = 1'b0;
        read_head(hw);
        check("post rst head", 32'(hw), 32'h7555);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Illegal-instruction flag
`ifdef IDEC_ILLEGAL_DET_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        in_valid = 1'b1; ir = 16'hC800; tick();
        in_valid = 1'b0;
        check("illegal flag", 32'(illegal), 32'(exp_ill));
        check("illegal out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check_empty("illegal popped");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
